// File: rtl/store_buffer_pkg.sv
// Shared store-buffer definitions: default depth, pointer width and the buffered entry record.
package store_buffer_pkg;

  localparam int unsigned SbDepthDefault = 4;
  localparam int unsigned SbPtrW         = $clog2(SbDepthDefault);

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } sb_entry_t;

endpackage

// File: rtl/sb_fifo.sv
// Entry storage plus head/tail/count bookkeeping for the store buffer.
module sb_fifo
  import store_buffer_pkg::*;
#(
  parameter int unsigned DEPTH = SbDepthDefault,
  localparam int unsigned PtrW = $clog2(DEPTH),
  localparam int unsigned CntW = PtrW + 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  push_i,
  input  sb_entry_t             push_entry_i,
  input  logic                  pop_i,
  output sb_entry_t             head_entry_o,
  output logic [PtrW-1:0]       head_o,
  output logic [CntW-1:0]       count_o,
  output sb_entry_t [DEPTH-1:0] entries_o
);

  sb_entry_t       mem_q [DEPTH];
  logic [PtrW-1:0] head_q, head_d;
  logic [PtrW-1:0] tail_q, tail_d;
  logic [CntW-1:0] count_q, count_d;

  // Storage is deliberately left unreset; count alone defines which entries are live.
  always_ff @(posedge clk) begin
    if (push_i) begin
      mem_q[tail_q] <= push_entry_i;
    end
  end

  // DEPTH is a power of two, so pointer overflow is the modulo wrap.
  always_comb begin
    head_d  = head_q + PtrW'(pop_i);
    tail_d  = tail_q + PtrW'(push_i);
    count_d = count_q + CntW'(push_i) - CntW'(pop_i);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  always_comb begin
    for (int unsigned i = 0; i < DEPTH; i++) begin
      entries_o[i] = mem_q[i];
    end
  end

  assign head_entry_o = mem_q[head_q];
  assign head_o       = head_q;
  assign count_o      = count_q;

endmodule

// File: rtl/store_buffer.sv
// MEM-stage store buffer: queues aligned stores, drains them when the load path is idle,
// and forwards the youngest matching pending store to loads.
module store_buffer
  import store_buffer_pkg::*;
#(
  parameter int unsigned DEPTH = SbDepthDefault
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        st_valid,
  input  logic [31:0] st_addr,
  input  logic [31:0] st_data,
  input  logic        ld_valid,
  input  logic [31:0] ld_addr,
  output logic [31:0] ld_data,
  output logic        stall,
  output logic        misalign,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  output logic        empty
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  sb_entry_t             push_entry;
  sb_entry_t             head_entry;
  sb_entry_t [DEPTH-1:0] entries;
  logic [PtrW-1:0]       head;
  logic [CntW-1:0]       count;
  logic                  st_mis, ld_mis, full, push, drain;
  logic                  fwd_hit;
  logic [31:0]           fwd_data;
  logic [PtrW-1:0]       fwd_idx;

  assign st_mis   = st_valid && (st_addr[1:0] != 2'b00);
  assign ld_mis   = ld_valid && (ld_addr[1:0] != 2'b00);
  assign misalign = st_mis || ld_mis;
  assign full     = (count == CntW'(DEPTH));
  assign empty    = (count == '0);

  assign stall = st_valid && !st_mis && full;
  assign push  = st_valid && !st_mis && !full;
  // A load owns the memory port; draining only happens on load-free cycles.
  assign drain = !ld_valid && !empty;

  assign push_entry.addr = st_addr;
  assign push_entry.data = st_data;

  sb_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk          (clk),
    .reset        (reset),
    .push_i       (push),
    .push_entry_i (push_entry),
    .pop_i        (drain),
    .head_entry_o (head_entry),
    .head_o       (head),
    .count_o      (count),
    .entries_o    (entries)
  );

  // Walk oldest to youngest so the last hit wins.
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    fwd_idx  = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      fwd_idx = head + PtrW'(i);
      if ((CntW'(i) < count) && (entries[fwd_idx].addr[31:2] == ld_addr[31:2])) begin
        fwd_hit  = 1'b1;
        fwd_data = entries[fwd_idx].data;
      end
    end
  end

  always_comb begin
    mem_we    = drain;
    mem_addr  = '0;
    mem_wdata = '0;
    if (ld_valid) begin
      mem_addr = ld_addr;
    end else if (drain) begin
      mem_addr  = head_entry.addr;
      mem_wdata = head_entry.data;
    end
  end

  always_comb begin
    ld_data = '0;
    if (ld_valid && !ld_mis) begin
      ld_data = fwd_hit ? fwd_data : mem_rdata;
    end
  end

endmodule

// File: tb/tb_store_buffer.sv
// Directed self-checking bench for store_buffer (DEPTH = 4).
module tb_store_buffer;

  logic        clk = 1'b0;
  logic        reset;
  logic        st_valid;
  logic [31:0] st_addr;
  logic [31:0] st_data;
  logic        ld_valid;
  logic [31:0] ld_addr;
  logic [31:0] ld_data;
  logic        stall;
  logic        misalign;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        empty;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  // Memory model: read word encodes the low address half under a fixed tag.
  assign mem_rdata = {16'hA5A5, mem_addr[15:0]};

  store_buffer #(
    .DEPTH (4)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .st_valid  (st_valid),
    .st_addr   (st_addr),
    .st_data   (st_data),
    .ld_valid  (ld_valid),
    .ld_addr   (ld_addr),
    .ld_data   (ld_data),
    .stall     (stall),
    .misalign  (misalign),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .empty     (empty)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  // Apply inputs just after the falling edge; checks follow #1 later, well clear of posedge.
  task automatic drive(input logic sv, input logic [31:0] sa, input logic [31:0] sd,
                       input logic lv, input logic [31:0] la);
    @(negedge clk);
    st_valid = sv;
    st_addr  = sa;
    st_data  = sd;
    ld_valid = lv;
    ld_addr  = la;
    #1;
  endtask

  task automatic idle();
    drive(1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    st_valid = 1'b0;
    ld_valid = 1'b0;
    #1;
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    reset    = 1'b0;
    st_valid = 1'b0;
    st_addr  = '0;
    st_data  = '0;
    ld_valid = 1'b0;
    ld_addr  = '0;
    #1;
    check("rst_empty", 32'(empty), 32'd1);
    check("rst_stall", 32'(stall), 32'd0);
    check("rst_we", 32'(mem_we), 32'd0);
    check("rst_addr", mem_addr, 32'h0);
    @(negedge clk);
    reset = 1'b1;

    // Single store, drained the cycle after it is enqueued.
    drive(1'b1, 32'h8, 32'hDEADBEEF, 1'b0, 32'h0);
    check("st1_we_same_cycle", 32'(mem_we), 32'd0);
    check("st1_stall", 32'(stall), 32'd0);
    idle();
    check("st1_drain_we", 32'(mem_we), 32'd1);
    check("st1_drain_addr", mem_addr, 32'h8);
    check("st1_drain_data", mem_wdata, 32'hDEADBEEF);
    check("st1_not_empty", 32'(empty), 32'd0);
    idle();
    check("st1_empty_after", 32'(empty), 32'd1);
    check("st1_idle_we", 32'(mem_we), 32'd0);
    check("st1_idle_addr", mem_addr, 32'h0);

    // Fill with a load held on the port; fifth store must stall.
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 32'(4 * i), 32'h100 + 32'(i), 1'b1, 32'h20);
      check("fill_stall", 32'(stall), 32'd0);
      check("fill_ld_data", ld_data, 32'hA5A50020);
      check("fill_we", 32'(mem_we), 32'd0);
      check("fill_addr", mem_addr, 32'h20);
    end
    drive(1'b1, 32'h10, 32'h999, 1'b1, 32'h20);
    check("full_stall", 32'(stall), 32'd1);
    check("full_ld_data", ld_data, 32'hA5A50020);
    for (int i = 0; i < 4; i++) begin
      idle();
      check("fill_drain_we", 32'(mem_we), 32'd1);
      check("fill_drain_addr", mem_addr, 32'(4 * i));
      check("fill_drain_data", mem_wdata, 32'h100 + 32'(i));
    end
    idle();
    check("fill_no_fifth", 32'(mem_we), 32'd0);
    check("fill_empty", 32'(empty), 32'd1);

    // Forwarding: same-cycle store invisible, youngest match wins.
    drive(1'b1, 32'h10, 32'h1, 1'b1, 32'h10);
    check("fwd_same_cycle", ld_data, 32'hA5A50010);
    drive(1'b1, 32'h10, 32'h2, 1'b1, 32'h10);
    check("fwd_older", ld_data, 32'h1);
    drive(1'b0, 32'h0, 32'h0, 1'b1, 32'h10);
    check("fwd_youngest", ld_data, 32'h2);
    check("fwd_stall", 32'(stall), 32'd0);
    drive(1'b0, 32'h0, 32'h0, 1'b1, 32'h14);
    check("fwd_miss", ld_data, 32'hA5A50014);
    drive(1'b0, 32'h0, 32'h0, 1'b1, 32'h11);
    check("ld_mis_flag", 32'(misalign), 32'd1);
    check("ld_mis_data", ld_data, 32'h0);
    idle();
    check("fwd_drain0_data", mem_wdata, 32'h1);
    idle();
    check("fwd_drain1_data", mem_wdata, 32'h2);
    idle();
    check("fwd_empty", 32'(empty), 32'd1);

    // Wrap: three entries (tail=3), then store and drain together.
    do_reset();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 32'h100 + 32'(4 * i), 32'hA0 + 32'(i), 1'b1, 32'h40);
    end
    drive(1'b1, 32'h10C, 32'hA3, 1'b0, 32'h0);
    check("wrap_we", 32'(mem_we), 32'd1);
    check("wrap_addr", mem_addr, 32'h100);
    check("wrap_data", mem_wdata, 32'hA0);
    check("wrap_stall", 32'(stall), 32'd0);
    for (int i = 1; i < 4; i++) begin
      idle();
      check("wrap_order_addr", mem_addr, 32'h100 + 32'(4 * i));
      check("wrap_order_data", mem_wdata, 32'hA0 + 32'(i));
    end
    idle();
    check("wrap_empty", 32'(empty), 32'd1);

    // Misaligned store is dropped.
    drive(1'b1, 32'h6, 32'h55, 1'b0, 32'h0);
    check("st_mis_flag", 32'(misalign), 32'd1);
    check("st_mis_stall", 32'(stall), 32'd0);
    check("st_mis_we", 32'(mem_we), 32'd0);
    idle();
    check("st_mis_dropped_we", 32'(mem_we), 32'd0);
    check("st_mis_empty", 32'(empty), 32'd1);

    // Reset mid-drain discards pending entries.
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 32'h200 + 32'(4 * i), 32'hB0 + 32'(i), 1'b1, 32'h40);
    end
    idle();
    check("rst_mid_we_before", 32'(mem_we), 32'd1);
    reset = 1'b0;
    #1;
    check("rst_mid_we", 32'(mem_we), 32'd0);
    check("rst_mid_empty", 32'(empty), 32'd1);
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      idle();
      check("rst_mid_no_write", 32'(mem_we), 32'd0);
    end
    check("rst_mid_empty_after", 32'(empty), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
